// File: rtl/fen_board_stream.sv
// fen_board_stream: expands the piece-placement field of a FEN byte stream
// into 64 per-square records (a8..h8, ..., a1..h1) and flags malformed boards.
// Optional feature: define FEN_SIDE_EN to decode the side-to-move character
// that follows the board field. Without it, out_black_to_move and
// out_side_valid stay 0.
module fen_board_stream #(
    parameter int CHAR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic [CHAR_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_pos_valid,
    output logic              out_pos_sop,
    output logic              out_pos_eop,
    output logic [3:0]        out_pos_piece,
    output logic              out_error,
    output logic              out_black_to_move,
    output logic              out_side_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BOARD,
        S_EXPAND,
        S_TAIL,
        S_SKIP
    } state_t;

    localparam logic [6:0] C_SPACE = 7'h20;
    localparam logic [6:0] C_SLASH = 7'h2F;
    localparam logic [6:0] C_ONE   = 7'h31;
    localparam logic [6:0] C_EIGHT = 7'h38;
    localparam logic [6:0] C_LOW_B = 7'h62;
    localparam logic [6:0] C_LOW_W = 7'h77;

    state_t      r_state;
    logic [6:0]  r_sq;
    logic [3:0]  r_file;
    logic [2:0]  r_rank;
    logic [2:0]  r_run;
    logic        r_pos_valid;
    logic        r_pos_sop;
    logic        r_pos_eop;
    logic [3:0]  r_pos_piece;
    logic        r_error;
    logic        r_btm;
    logic        r_side_valid;

    state_t      w_state_next;
    logic [6:0]  w_sq_next;
    logic [3:0]  w_file_next;
    logic [2:0]  w_rank_next;
    logic [2:0]  w_run_next;
    logic        w_emit;
    logic [3:0]  w_emit_piece;
    logic [6:0]  w_emit_idx;
    logic        w_bad;
    logic        w_side_valid_next;
    logic        w_btm_next;

    logic        w_accept;
    logic        w_hi_ok;
    logic [6:0]  w_ch;
    logic [2:0]  w_ptype;
    logic        w_pblack;
    logic        w_is_digit;
    logic [3:0]  w_n;
    logic [6:0]  w_base_sq;
    logic [3:0]  w_base_file;
    logic [2:0]  w_base_rank;
    logic [4:0]  w_piece_end;
    logic [4:0]  w_digit_end;

    // A new string's first character may preempt an expansion in progress,
    // so a valid in_sop is always accepted.
    assign in_ready = (r_state != S_EXPAND) || (in_valid && in_sop);
    assign w_accept = in_valid && in_ready;
    assign w_ch     = in_data[6:0];

    // Characters with any bit above the ASCII range set are illegal.
    generate
        if (CHAR_W > 7) begin : g_hi
            assign w_hi_ok = (in_data[CHAR_W-1:7] == '0);
        end else begin : g_nohi
            assign w_hi_ok = 1'b1;
        end
    endgenerate

    assign w_is_digit = (w_ch >= C_ONE) && (w_ch <= C_EIGHT);
    assign w_n        = w_ch[3:0];

    // A sop character starts from cleared counters whatever the current state.
    assign w_base_sq   = in_sop ? 7'd0 : r_sq;
    assign w_base_file = in_sop ? 4'd0 : r_file;
    assign w_base_rank = in_sop ? 3'd0 : r_rank;
    assign w_piece_end = {1'b0, w_base_file} + 5'd1;
    assign w_digit_end = {1'b0, w_base_file} + {1'b0, w_n};

    // Piece letter decode: type code and colour.
    always_comb begin
        w_ptype  = 3'd0;
        w_pblack = 1'b0;
        case (w_ch)
            7'h50: w_ptype = 3'd1;                    // P
            7'h4E: w_ptype = 3'd2;                    // N
            7'h42: w_ptype = 3'd3;                    // B
            7'h52: w_ptype = 3'd4;                    // R
            7'h51: w_ptype = 3'd5;                    // Q
            7'h4B: w_ptype = 3'd6;                    // K
            7'h70: begin w_ptype = 3'd1; w_pblack = 1'b1; end // p
            7'h6E: begin w_ptype = 3'd2; w_pblack = 1'b1; end // n
            7'h62: begin w_ptype = 3'd3; w_pblack = 1'b1; end // b
            7'h72: begin w_ptype = 3'd4; w_pblack = 1'b1; end // r
            7'h71: begin w_ptype = 3'd5; w_pblack = 1'b1; end // q
            7'h6B: begin w_ptype = 3'd6; w_pblack = 1'b1; end // k
            default: ;
        endcase
    end

    // Next-state, counter and record generation.
    always_comb begin
        w_state_next      = r_state;
        w_sq_next         = r_sq;
        w_file_next       = r_file;
        w_rank_next       = r_rank;
        w_run_next        = r_run;
        w_emit            = 1'b0;
        w_emit_piece      = 4'd0;
        w_emit_idx        = r_sq;
        w_bad             = 1'b0;
        w_side_valid_next = 1'b0;
        w_btm_next        = r_btm;

        if (w_accept && (in_sop || r_state == S_BOARD)) begin
            w_state_next = S_BOARD;
            w_sq_next    = w_base_sq;
            w_file_next  = w_base_file;
            w_rank_next  = w_base_rank;
            w_run_next   = 3'd0;
            w_emit_idx   = w_base_sq;
            if (!w_hi_ok) begin
                w_bad = 1'b1;
            end else if (w_base_sq == 7'd64) begin
                // Board complete: only the separating space is legal.
                if (w_ch == C_SPACE) w_state_next = S_TAIL;
                else                 w_bad = 1'b1;
            end else if (w_ptype != 3'd0) begin
                if (w_piece_end > 5'd8) begin
                    w_bad = 1'b1;
                end else begin
                    w_emit       = 1'b1;
                    w_emit_piece = {w_pblack, w_ptype};
                    w_file_next  = w_piece_end[3:0];
                    w_sq_next    = w_base_sq + 7'd1;
                end
            end else if (w_is_digit) begin
                if (w_digit_end > 5'd8) begin
                    w_bad = 1'b1;
                end else begin
                    // First empty goes out now, the rest from EXPAND.
                    w_emit      = 1'b1;
                    w_file_next = w_digit_end[3:0];
                    w_sq_next   = w_base_sq + 7'd1;
                    if (w_n > 4'd1) begin
                        w_run_next   = 3'(w_n - 4'd1);
                        w_state_next = S_EXPAND;
                    end
                end
            end else if (w_ch == C_SLASH) begin
                if (w_base_file == 4'd8 && w_base_rank != 3'd7) begin
                    w_file_next = 4'd0;
                    w_rank_next = w_base_rank + 3'd1;
                end else begin
                    w_bad = 1'b1;
                end
            end else begin
                w_bad = 1'b1;
            end
        end else begin
            case (r_state)
                S_EXPAND: begin
                    w_emit     = 1'b1;
                    w_sq_next  = (r_sq == 7'd64) ? r_sq : r_sq + 7'd1;
                    w_run_next = r_run - 3'd1;
                    if (r_run == 3'd1) w_state_next = S_BOARD;
                end
                S_TAIL: begin
                    if (w_accept) begin
`ifdef FEN_SIDE_EN
                        if (w_hi_ok && w_ch == C_LOW_W) begin
                            w_btm_next        = 1'b0;
                            w_side_valid_next = 1'b1;
                        end else if (w_hi_ok && w_ch == C_LOW_B) begin
                            w_btm_next        = 1'b1;
                            w_side_valid_next = 1'b1;
                        end else begin
                            w_bad = 1'b1;
                        end
`endif
                        w_state_next = S_SKIP;
                    end
                end
                default: ;
            endcase
        end

        if (w_bad) begin
            w_emit       = 1'b0;
            w_state_next = S_SKIP;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_sq         <= 7'd0;
            r_file       <= 4'd0;
            r_rank       <= 3'd0;
            r_run        <= 3'd0;
            r_pos_valid  <= 1'b0;
            r_pos_sop    <= 1'b0;
            r_pos_eop    <= 1'b0;
            r_pos_piece  <= 4'd0;
            r_error      <= 1'b0;
            r_btm        <= 1'b0;
            r_side_valid <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_sq         <= w_sq_next;
            r_file       <= w_file_next;
            r_rank       <= w_rank_next;
            r_run        <= w_run_next;
            r_pos_valid  <= w_emit;
            r_pos_sop    <= w_emit && (w_emit_idx == 7'd0);
            r_pos_eop    <= w_emit && (w_emit_idx == 7'd63);
            r_pos_piece  <= w_emit ? w_emit_piece : 4'd0;
            r_error      <= w_bad;
            r_btm        <= w_btm_next;
            r_side_valid <= w_side_valid_next;
        end
    end

    assign out_pos_valid     = r_pos_valid;
    assign out_pos_sop       = r_pos_sop;
    assign out_pos_eop       = r_pos_eop;
    assign out_pos_piece     = r_pos_piece;
    assign out_error         = r_error;
    assign out_black_to_move = r_btm;
    assign out_side_valid    = r_side_valid;

endmodule

// File: tb/tb_fen_board_stream.sv
// Testbench for fen_board_stream: directed FEN cases plus randomly generated
// (and randomly corrupted) boards, checked against a string-level FEN model.
module tb_fen_board_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_sop = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready;
    logic       out_pos_valid;
    logic       out_pos_sop;
    logic       out_pos_eop;
    logic [3:0] out_pos_piece;
    logic       out_error;
    logic       out_black_to_move;
    logic       out_side_valid;

    fen_board_stream #(.CHAR_W(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_sop            (in_sop),
        .in_data           (in_data),
        .in_ready          (in_ready),
        .out_pos_valid     (out_pos_valid),
        .out_pos_sop       (out_pos_sop),
        .out_pos_eop       (out_pos_eop),
        .out_pos_piece     (out_pos_piece),
        .out_error         (out_error),
        .out_black_to_move (out_black_to_move),
        .out_side_valid    (out_side_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed stream; record encoding = piece + 16*eop + 32*sop.
    int got_q[$];
    int got_cyc[$];
    int err_cnt = 0;
    int side_cnt = 0;
    int side_val = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (out_pos_valid) begin
                got_q.push_back(int'(out_pos_piece) + (out_pos_eop ? 16 : 0) + (out_pos_sop ? 32 : 0));
                got_cyc.push_back(cyc);
            end
            if (out_error) err_cnt = err_cnt + 1;
            if (out_side_valid) begin
                side_cnt = side_cnt + 1;
                side_val = int'(out_black_to_move);
            end
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Expected results
    int exp_q[$];
    int exp_err;
    int exp_side_cnt;
    int exp_side;

    // String-level FEN model: appends this string's expected records.
    task automatic model_fen(input string s);
        int    sq = 0;
        int    file = 0;
        int    rank = 0;
        int    phase = 0;   // 0 board, 1 after board space, 2 done
        string pw = "PNBRQK";
        for (int i = 0; i < s.len(); i++) begin
            logic [7:0] c;
            int code;
            int n;
            bit err;
            c = s[i];
            code = -1;
            n = 0;
            err = 0;
            if (phase == 2) continue;
            if (phase == 1) begin
`ifdef FEN_SIDE_EN
                if (c == "w") begin exp_side_cnt++; exp_side = 0; end
                else if (c == "b") begin exp_side_cnt++; exp_side = 1; end
                else exp_err++;
`endif
                phase = 2;
                continue;
            end
            for (int k = 0; k < 6; k++) begin
                if (c == pw[k]) code = k + 1;
                if (c == (pw[k] | 8'h20)) code = k + 9;
            end
            if (c[7]) err = 1;
            else if (sq == 64) begin
                if (c == " ") phase = 1; else err = 1;
            end else if (code > 0) begin
                if (file + 1 > 8) err = 1;
                else begin
                    exp_q.push_back(code + (sq == 0 ? 32 : 0) + (sq == 63 ? 16 : 0));
                    sq++; file++;
                end
            end else if (c >= "1" && c <= "8") begin
                n = int'(c) - 48;
                if (file + n > 8) err = 1;
                else begin
                    for (int k = 0; k < n; k++) begin
                        exp_q.push_back((sq == 0 ? 32 : 0) + (sq == 63 ? 16 : 0));
                        sq++;
                    end
                    file += n;
                end
            end else if (c == "/") begin
                if (file == 8 && rank < 7) begin file = 0; rank++; end
                else err = 1;
            end else err = 1;
            if (err) begin
                exp_err++;
                phase = 2;
            end
        end
    endtask

    task automatic clear_exp();
        exp_q.delete();
        exp_err = 0;
        exp_side_cnt = 0;
        exp_side = 0;
    endtask

    // Drives characters; entered and left at posedge+1.
    task automatic send_str(input string s, input bit gaps, input bit first_sop);
        for (int i = 0; i < s.len(); i++) begin
            bit acc;
            int tries;
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_sop   = first_sop && (i == 0);
            in_data  = s[i];
            acc = 0;
            tries = 0;
            while (!acc && tries < 100) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                tries++;
            end
            if (!acc) check("accept_timeout", 0, 1);
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic drain();
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic compare(input string tag, input int q0, input int e0, input int s0);
        int n;
        n = got_q.size() - q0;
        check({tag, "_nrec"}, n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++)
            check($sformatf("%s_rec%0d", tag, i), got_q[q0 + i], exp_q[i]);
        check({tag, "_err"}, err_cnt - e0, exp_err);
        check({tag, "_side_n"}, side_cnt - s0, exp_side_cnt);
        if (exp_side_cnt > 0) check({tag, "_side"}, side_val, exp_side);
        $display("case %s: records=%0d errors=%0d side=%0d", tag, n, err_cnt - e0, side_cnt - s0);
    endtask

    task automatic run_case(input string tag, input string s, input bit gaps, output int q0);
        int e0;
        int s0;
        q0 = got_q.size();
        e0 = err_cnt;
        s0 = side_cnt;
        clear_exp();
        model_fen(s);
        send_str(s, gaps, 1'b1);
        drain();
        compare(tag, q0, e0, s0);
    endtask

    function automatic string gen_fen();
        string pcs = "PNBRQKpnbrqk";
        string bads = "x0/9 8pKw";
        string s = "";
        int run;
        int p;
        int sel;
        logic [7:0] c;
        for (int r = 0; r < 8; r++) begin
            run = 0;
            for (int f = 0; f < 8; f++) begin
                if ($urandom_range(0, 2) == 0) begin
                    if (run > 0) s = $sformatf("%s%0d", s, run);
                    run = 0;
                    s = $sformatf("%s%c", s, pcs[$urandom_range(0, 11)]);
                end else run++;
            end
            if (run > 0) s = $sformatf("%s%0d", s, run);
            if (r < 7) s = {s, "/"};
        end
        s = {s, ($urandom_range(0, 1) != 0) ? " b - - 0 1" : " w KQkq - 0 1"};
        if ($urandom_range(0, 1) != 0) begin
            p = $urandom_range(0, s.len() - 1);
            sel = $urandom_range(0, 9);
            if (sel == 9) c = 8'hD0;
            else c = bads[sel];
            s.putc(p, c);
        end
        return s;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=0 exp=1");
        $fatal(1, "timeout");
    end

    initial begin
        string start;
        string s;
        int q0;
        int e0;
        int s0;
        int lowc;
        start = "rnbqkbnr/pppppppp/8/8/8/8/PPPPPPPP/RNBQKBNR w KQkq - 0 1";

        // Reset state
        #3;
        check("rst_ready", int'(in_ready), 1);
        check("rst_valid", int'(out_pos_valid), 0);
        check("rst_error", int'(out_error), 0);
        check("rst_side_valid", int'(out_side_valid), 0);
        check("rst_btm", int'(out_black_to_move), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Start position with spot checks
        run_case("start", start, 1'b0, q0);
        if (got_q.size() >= q0 + 64) begin
            check("start_r0", got_q[q0], 32 + 12);
            check("start_r8", got_q[q0 + 8], 9);
            check("start_r16", got_q[q0 + 16], 0);
            check("start_r47", got_q[q0 + 47], 0);
            check("start_r56", got_q[q0 + 56], 4);
            check("start_r63", got_q[q0 + 63], 16 + 4);
        end else check("start_len", got_q.size() - q0, 64);

        // Leading '8': in_ready low 7 cycles, 8 consecutive empties
        s = "8/8/8/8/8/8/8/8 b - - 0 1";
        q0 = got_q.size(); e0 = err_cnt; s0 = side_cnt;
        clear_exp();
        model_fen(s);
        in_valid = 1'b1; in_sop = 1'b1; in_data = "8";
        @(negedge clk);
        check("run8_accept", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_sop = 1'b0;
        lowc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) break;
            lowc++;
        end
        check("run8_ready_low", lowc, 7);
        @(posedge clk); #1;
        send_str(s.substr(1, s.len() - 1), 1'b0, 1'b0);
        drain();
        compare("run8", q0, e0, s0);
        for (int i = 1; i < 8; i++)
            if (got_cyc.size() > q0 + i)
                check($sformatf("run8_cyc%0d", i), got_cyc[q0 + i] - got_cyc[q0], i);

        // Nine pawns in a rank
        run_case("nine_pawns", "rnbqkbnr/ppppppppp/8/8/8/8/PPPPPPPP/RNBQKBNR w - - 0 1", 1'b0, q0);
        check("nine_pawns_ready", int'(in_ready), 1);

        // sop while an expansion has 4 empties pending
        q0 = got_q.size(); e0 = err_cnt; s0 = side_cnt;
        clear_exp();
        model_fen("5");
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        model_fen(start);
        in_valid = 1'b1; in_sop = 1'b1; in_data = "5";
        @(negedge clk); @(posedge clk); #1;
        send_str(start, 1'b0, 1'b1);
        drain();
        compare("preempt", q0, e0, s0);

        // Random input gaps on the start position
        run_case("start_gaps", start, 1'b1, q0);

        // Truncated board (63 squares) then space
        run_case("trunc", "rnbqkbnr/pppppppp/8/8/8/8/PPPPPPPP/RNBQKBN w KQkq - 0 1", 1'b0, q0);

        // Random boards, some corrupted
        for (int t = 0; t < 30; t++)
            run_case($sformatf("rand%0d", t), gen_fen(), 1'b1, q0);

        // Reset in the middle of a string
        send_str("rnbq", 1'b0, 1'b1);
        check("pre_rst_valid", int'(out_pos_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", int'(out_pos_valid), 0);
        check("mid_rst_piece", int'(out_pos_piece), 0);
        check("mid_rst_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        q0 = got_q.size(); e0 = err_cnt;
        send_str("PPP", 1'b0, 1'b0);
        drain();
        check("idle_drop_rec", got_q.size() - q0, 0);
        check("idle_drop_err", err_cnt - e0, 0);
        $display("case idle_drop: records=%0d", got_q.size() - q0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
